// File: rtl/md5_pkg.sv
// Shared widths and FSM encoding for the md5 digest matcher.
package md5_pkg;
  localparam int WORD_W   = 32;
  localparam int DIGEST_W = 128;
  localparam int MSG_W    = 512;
  localparam int CAND_W   = 448;
  localparam int N_WORDS  = DIGEST_W / WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_FOUND  = 2'd2
  } state_e;

  typedef struct packed {
    logic               vld;
    logic [N_WORDS-1:0] eq;
    logic [CAND_W-1:0]  msg;
  } cmp_s1_t;
endpackage

// File: rtl/md5_cmp_pipe.sv
// Two-stage digest compare: per-word equality flags, then the all-equal hit.
module md5_cmp_pipe
  import md5_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                clr,
  input  logic [WORD_W-1:0]   a_in,
  input  logic [WORD_W-1:0]   b_in,
  input  logic [WORD_W-1:0]   c_in,
  input  logic [WORD_W-1:0]   d_in,
  input  logic [CAND_W-1:0]   m_cand,
  input  logic                valid_in,
  input  logic [DIGEST_W-1:0] target,
  output logic                hit,
  output logic [CAND_W-1:0]   hit_m
);
  logic [N_WORDS-1:0][WORD_W-1:0] words, tgt;
  logic [N_WORDS-1:0]             eq;
  cmp_s1_t                        s1;

  // Index N_WORDS-1 is a_in against target[127:96]; index 0 is d_in.
  assign words = {a_in, b_in, c_in, d_in};
  assign tgt   = target;

  for (genvar i = 0; i < N_WORDS; i++) begin : g_eq
    assign eq[i] = (words[i] == tgt[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      hit   <= 1'b0;
      hit_m <= '0;
    end else if (en) begin
      s1.vld <= valid_in & ~clr;
      s1.eq  <= eq;
      s1.msg <= m_cand;
      hit    <= s1.vld & (&s1.eq) & ~clr;
      hit_m  <= s1.msg;
    end
  end
endmodule

// File: rtl/md5_match.sv
// Watches md5 core output for a target digest; holds the first match until acked.
module md5_match
  import md5_pkg::*;
#(
  parameter int COUNT_W = 48
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [WORD_W-1:0]   a_in,
  input  logic [WORD_W-1:0]   b_in,
  input  logic [WORD_W-1:0]   c_in,
  input  logic [WORD_W-1:0]   d_in,
  input  logic [MSG_W-1:0]    m_in,
  input  logic                valid_in,
  input  logic [DIGEST_W-1:0] target,
  input  logic                target_load,
  input  logic                start,
  input  logic                stop,
  input  logic                match_ack,
  output logic                match_valid,
  output logic [CAND_W-1:0]   match_m,
  output logic [COUNT_W-1:0]  hash_count,
  output logic                busy,
  output logic                dropped
);
  state_e              state_q, state_d;
  logic [DIGEST_W-1:0] target_q;
  logic                hit, capture, set_drop, clr_run, cnt_inc, searching;
  logic [CAND_W-1:0]   hit_m;
  logic                pad_unused;

  // Length pad never matters for the match; only the candidate string is kept.
  assign pad_unused = ^m_in[MSG_W-CAND_W-1:0];
  assign searching  = (state_q != ST_IDLE);

  md5_cmp_pipe u_cmp (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (clr_run | stop),
    .a_in     (a_in),
    .b_in     (b_in),
    .c_in     (c_in),
    .d_in     (d_in),
    .m_cand   (m_in[MSG_W-1:MSG_W-CAND_W]),
    .valid_in (valid_in & searching),
    .target   (target_q),
    .hit      (hit),
    .hit_m    (hit_m)
  );

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    set_drop = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (start) state_d = ST_SEARCH;
        ST_SEARCH: if (hit) begin
          state_d = ST_FOUND;
          capture = 1'b1;
        end
        ST_FOUND: begin
          if (hit && match_ack) capture  = 1'b1;
          else if (hit)         set_drop = 1'b1;
          else if (match_ack)   state_d  = ST_SEARCH;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    clr_run = (state_q == ST_IDLE) && start && !stop;
    cnt_inc = valid_in && searching && !stop && (hash_count != '1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else if (en) state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q   <= '0;
      match_m    <= '0;
      hash_count <= '0;
      dropped    <= 1'b0;
    end else if (en) begin
      if (target_load && state_q == ST_IDLE) target_q <= target;
      if (capture) match_m <= hit_m;
      if (clr_run) begin
        hash_count <= '0;
        dropped    <= 1'b0;
      end else begin
        if (cnt_inc)  hash_count <= hash_count + 1'b1;
        if (set_drop) dropped    <= 1'b1;
      end
    end
  end

  assign match_valid = (state_q == ST_FOUND);
  assign busy        = searching;
endmodule

// File: tb/tb_md5_match.sv
// Self-checking bench for md5_match: vector table with scoreboard plus corner sequences.
module tb_md5_match;
  localparam logic [127:0] TGT = 128'hd41d8cd98f00b204e9800998ecf8427e;

  logic         clk = 1'b0;
  logic         reset, en, valid_in, target_load, start, stop, match_ack;
  logic [31:0]  a_in, b_in, c_in, d_in;
  logic [511:0] m_in;
  logic [127:0] target;
  logic         match_valid, busy, dropped;
  logic [447:0] match_m;
  logic [47:0]  hash_count;
  logic         s_mv, s_busy, s_drop;
  logic [447:0] s_mm;
  logic [1:0]   s_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  md5_match dut (
    .clk(clk), .reset(reset), .en(en), .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .m_in(m_in), .valid_in(valid_in), .target(target), .target_load(target_load),
    .start(start), .stop(stop), .match_ack(match_ack), .match_valid(match_valid),
    .match_m(match_m), .hash_count(hash_count), .busy(busy), .dropped(dropped)
  );

  // Narrow counter copy so saturation is reachable in a few cycles.
  md5_match #(.COUNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .en(en), .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .m_in(m_in), .valid_in(valid_in), .target(target), .target_load(target_load),
    .start(start), .stop(stop), .match_ack(match_ack), .match_valid(s_mv),
    .match_m(s_mm), .hash_count(s_cnt), .busy(s_busy), .dropped(s_drop)
  );

  typedef struct {
    logic [127:0] dig;
    logic [447:0] msg;
    logic         exp_hit;
  } vec_t;

  typedef struct {
    logic         mv;
    logic [447:0] m;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  task automatic chk(input string name, input logic [447:0] act, input logic [447:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [447:0] mk_msg(input logic [7:0] tag);
    return {tag, {55{tag ^ 8'h5a}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dig(input logic [127:0] dig, input logic [447:0] msg);
    {a_in, b_in, c_in, d_in} = dig;
    m_in     = {msg, 64'h0000_0000_0000_0040};
    valid_in = 1'b1;
  endtask

  task automatic send(input logic [127:0] dig, input logic [447:0] msg);
    drive_dig(dig, msg);
    tick();
    valid_in = 1'b0;
  endtask

  task automatic ack();
    match_ack = 1'b1;
    tick();
    match_ack = 1'b0;
  endtask

  initial begin
    logic [127:0] one;
    logic [447:0] last_cap;
    logic         seen_mv;
    exp_t         e;
    one = 128'd1;

    reset = 1'b1; en = 1'b1; valid_in = 1'b0; target_load = 1'b0; start = 1'b0;
    stop = 1'b0; match_ack = 1'b0; target = '0; m_in = '0;
    a_in = '0; b_in = '0; c_in = '0; d_in = '0;

    vecs[0] = '{TGT,               mk_msg(8'h11), 1'b1};
    vecs[1] = '{TGT ^ (one << 96), mk_msg(8'h12), 1'b0};
    vecs[2] = '{TGT ^ (one << 64), mk_msg(8'h13), 1'b0};
    vecs[3] = '{TGT ^ (one << 32), mk_msg(8'h14), 1'b0};
    vecs[4] = '{TGT ^ one,         mk_msg(8'h15), 1'b0};
    vecs[5] = '{~TGT,              mk_msg(8'h16), 1'b0};
    vecs[6] = '{TGT,               mk_msg(8'h27), 1'b1};
    vecs[7] = '{TGT ^ (one << 127), mk_msg(8'h18), 1'b0};

    // Reset state
    tick(); tick();
    chk("rst_match_valid", 448'(match_valid), 448'(0));
    chk("rst_busy", 448'(busy), 448'(0));
    chk("rst_dropped", 448'(dropped), 448'(0));
    chk("rst_count", 448'(hash_count), 448'(0));
    chk("rst_match_m", match_m, 448'(0));
    reset = 1'b0;
    tick();

    // Load target, start, first match with latency check
    target = TGT; target_load = 1'b1; tick(); target_load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy", 448'(busy), 448'(1));
    drive_dig(TGT, mk_msg(8'h80)); tick(); valid_in = 1'b0;
    tick();
    chk("latency_not_yet", 448'(match_valid), 448'(0));
    tick();
    chk("first_match_valid", 448'(match_valid), 448'(1));
    chk("first_match_byte", 448'(match_m[447:440]), 448'(8'h80));
    chk("first_count", 448'(hash_count), 448'(1));
    last_cap = mk_msg(8'h80);
    ack();
    chk("ack_clears_valid", 448'(match_valid), 448'(0));

    // Counter saturation on the narrow instance
    send(~TGT, mk_msg(8'h01));
    chk("sat_all_ones_m1", 448'(s_cnt), 448'(2));
    send(~TGT, mk_msg(8'h02)); send(~TGT, mk_msg(8'h03)); send(~TGT, mk_msg(8'h04));
    chk("sat_saturated", 448'(s_cnt), 448'(3));
    chk("wide_count_5", 448'(hash_count), 448'(5));

    // Target load outside IDLE must not disturb the active target
    target = '0; target_load = 1'b1; tick(); target_load = 1'b0;

    // Table vectors through the scoreboard
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].dig, vecs[i].msg);
      sb.push_back('{vecs[i].exp_hit, vecs[i].exp_hit ? vecs[i].msg : last_cap});
      tick(); tick();
      e = sb.pop_front();
      chk($sformatf("vec%0d_valid", i), 448'(match_valid), 448'(e.mv));
      chk($sformatf("vec%0d_msg", i), match_m, e.m);
      last_cap = e.m;
      if (match_valid) ack();
    end
    chk("table_count", 448'(hash_count), 448'(13));

    // Enable low freezes everything
    en = 1'b0; drive_dig(TGT, mk_msg(8'h99)); start = 1'b1; stop = 1'b1; match_ack = 1'b1;
    tick(); tick(); tick();
    chk("en_low_count", 448'(hash_count), 448'(13));
    chk("en_low_busy", 448'(busy), 448'(1));
    valid_in = 1'b0; start = 1'b0; stop = 1'b0; match_ack = 1'b0; en = 1'b1;
    tick(); tick();
    chk("en_low_no_match", 448'(match_valid), 448'(0));

    // Back-to-back matches with no ack: first held, second dropped
    drive_dig(TGT, mk_msg(8'h31)); tick();
    drive_dig(TGT, mk_msg(8'h32)); tick(); valid_in = 1'b0;
    tick();
    chk("b2b_valid", 448'(match_valid), 448'(1));
    chk("b2b_msg_first", match_m, mk_msg(8'h31));
    chk("b2b_not_dropped_yet", 448'(dropped), 448'(0));
    tick();
    chk("b2b_dropped", 448'(dropped), 448'(1));
    chk("b2b_msg_held", match_m, mk_msg(8'h31));
    ack();
    chk("b2b_ack", 448'(match_valid), 448'(0));

    // Ack coincident with a new hit: replace and stay FOUND
    send(TGT, mk_msg(8'h41)); tick(); tick();
    chk("ackhit_first", match_m, mk_msg(8'h41));
    send(TGT, mk_msg(8'h42)); tick();
    match_ack = 1'b1; tick(); match_ack = 1'b0;
    chk("ackhit_valid", 448'(match_valid), 448'(1));
    chk("ackhit_msg", match_m, mk_msg(8'h42));
    ack();
    chk("ackhit_released", 448'(match_valid), 448'(0));

    // Ack in SEARCH is ignored
    ack();
    chk("ack_search_busy", 448'(busy), 448'(1));
    chk("ack_search_valid", 448'(match_valid), 448'(0));

    // Restart clears count and dropped; 1000 non-matching digests
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_idle", 448'(busy), 448'(0));
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_count", 448'(hash_count), 448'(0));
    chk("restart_dropped", 448'(dropped), 448'(0));
    seen_mv = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      drive_dig(TGT, mk_msg(8'h55));
      a_in = 32'(i) ^ 32'hffff_0000;
      tick();
      if (match_valid) seen_mv = 1'b1;
    end
    valid_in = 1'b0; tick(); tick();
    if (match_valid) seen_mv = 1'b1;
    chk("k1000_no_match", 448'(seen_mv), 448'(0));
    chk("k1000_count", 448'(hash_count), 448'(1000));

    // IDLE ignores valid_in
    stop = 1'b1; tick(); stop = 1'b0;
    send(TGT, mk_msg(8'h61)); tick(); tick();
    chk("idle_no_match", 448'(match_valid), 448'(0));
    chk("idle_no_count", 448'(hash_count), 448'(1000));

    // Stop one cycle after a matching digest
    start = 1'b1; tick(); start = 1'b0;
    drive_dig(TGT, mk_msg(8'h71)); tick(); valid_in = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_busy", 448'(busy), 448'(0));
    tick(); tick();
    chk("stop_no_match", 448'(match_valid), 448'(0));
    chk("stop_still_idle", 448'(busy), 448'(0));

    // Async reset one cycle after a matching digest
    start = 1'b1; tick(); start = 1'b0;
    drive_dig(TGT, mk_msg(8'h72)); tick(); valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("areset_busy", 448'(busy), 448'(0));
    chk("areset_count", 448'(hash_count), 448'(0));
    chk("areset_msg", match_m, 448'(0));
    tick(); reset = 1'b0;
    tick(); tick(); tick();
    chk("areset_no_match", 448'(match_valid), 448'(0));
    chk("areset_idle", 448'(busy), 448'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
